// File: rtl/counter_4bit_updown.sv
// Synchronous up/down counter with parallel load, count enable and synchronous reset.
// Define COUNTER_SAT_EN to saturate at the end values instead of wrapping.
module counter_4bit_updown #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ud,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] cin,
   output logic [WIDTH-1:0] cn
);

   localparam logic [WIDTH-1:0] CN_MAX = '1;
   localparam logic [WIDTH-1:0] CN_MIN = '0;
   localparam logic [WIDTH-1:0] CN_ONE = WIDTH'(1);

   logic [WIDTH-1:0] cn_d;
   logic [WIDTH-1:0] cn_q;
   logic             at_max;
   logic             at_min;

   assign at_max = (cn_q == CN_MAX);
   assign at_min = (cn_q == CN_MIN);

   // Reset is handled in the register; load outranks counting.
   always_comb begin
      cn_d = cn_q;
      if (load) begin
         cn_d = cin;
      end else if (en) begin
         if (ud) begin
`ifdef COUNTER_SAT_EN
            cn_d = at_max ? cn_q : cn_q + CN_ONE;
`else
            cn_d = cn_q + CN_ONE;
`endif
         end else begin
`ifdef COUNTER_SAT_EN
            cn_d = at_min ? cn_q : cn_q - CN_ONE;
`else
            cn_d = cn_q - CN_ONE;
`endif
         end
      end
   end

`ifndef COUNTER_SAT_EN
   // End-value flags only steer the saturating build.
   logic unused_flags;
   assign unused_flags = at_max ^ at_min;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         cn_q <= CN_MIN;
      end else begin
         cn_q <= cn_d;
      end
   end

   assign cn = cn_q;

endmodule

// File: tb/tb_counter_4bit_updown.sv
// Directed table-driven bench for counter_4bit_updown; expectations follow COUNTER_SAT_EN.
module tb_counter_4bit_updown;

   localparam int WIDTH = 4;
`ifdef COUNTER_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   typedef struct {
      logic             rst;
      logic             load;
      logic             en;
      logic             ud;
      logic [WIDTH-1:0] cin;
      logic [WIDTH-1:0] exp;
      string            name;
   } vec_t;

   logic             clk;
   logic             rst;
   logic             ud;
   logic             en;
   logic             load;
   logic [WIDTH-1:0] cin;
   logic [WIDTH-1:0] cn;

   int n_cmp;
   int n_bad;
   vec_t tbl[$];

   counter_4bit_updown #(.WIDTH(WIDTH)) dut (
      .clk  (clk),
      .rst  (rst),
      .ud   (ud),
      .en   (en),
      .load (load),
      .cin  (cin),
      .cn   (cn)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic r, input logic l, input logic e, input logic u,
                               input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] x,
                               input string nm);
      vec_t v;
      v.rst = r; v.load = l; v.en = e; v.ud = u; v.cin = c; v.exp = x; v.name = nm;
      return v;
   endfunction

   task automatic check(input string nm, input logic [WIDTH-1:0] exp);
      n_cmp++;
      if (cn !== exp) begin
         n_bad++;
         $display("FAIL %s: cn=%0d expected %0d", nm, cn, exp);
      end else begin
         $display("ok   %s: cn=%0d", nm, cn);
      end
   endtask

   task automatic apply(input vec_t v);
      @(negedge clk);
      rst = v.rst; load = v.load; en = v.en; ud = v.ud; cin = v.cin;
      @(posedge clk);
      #1;
      check(v.name, v.exp);
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst = 1'b1; load = 1'b0; en = 1'b0; ud = 1'b0; cin = '0;

      // Reset held with counting requested
      for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 0, 1, 1, 4'd0, 4'd0, "reset_hold"));
      // Reset beats load
      for (int i = 0; i < 2; i++) tbl.push_back(mk(1, 1, 0, 0, 4'd4, 4'd0, "reset_vs_load"));
      // Count up 16 edges: 1..15 then wrap (or saturate)
      for (int i = 1; i <= 15; i++) tbl.push_back(mk(0, 0, 1, 1, 4'd0, 4'(i), "count_up"));
      tbl.push_back(mk(0, 0, 1, 1, 4'd0, SAT ? 4'd15 : 4'd0, "up_wrap"));
      // Load 4 then count down through zero
      tbl.push_back(mk(0, 1, 0, 0, 4'd4, 4'd4, "load4"));
      for (int i = 3; i >= 0; i--) tbl.push_back(mk(0, 0, 1, 0, 4'd0, 4'(i), "count_down"));
      tbl.push_back(mk(0, 0, 1, 0, 4'd0, SAT ? 4'd0 : 4'd15, "down_wrap"));
      // Hold at 7 with ud toggling, then load beats count
      tbl.push_back(mk(0, 1, 0, 0, 4'd7, 4'd7, "load7"));
      tbl.push_back(mk(0, 0, 0, 1, 4'd9, 4'd7, "hold_ud1"));
      tbl.push_back(mk(0, 0, 0, 0, 4'd9, 4'd7, "hold_ud0"));
      tbl.push_back(mk(0, 0, 0, 1, 4'd9, 4'd7, "hold_ud1b"));
      tbl.push_back(mk(0, 1, 1, 1, 4'd12, 4'd12, "load_beats_count"));
      // Immediate direction change
      tbl.push_back(mk(0, 0, 1, 0, 4'd0, 4'd11, "dir_down"));
      tbl.push_back(mk(0, 0, 1, 1, 4'd0, 4'd12, "dir_up"));
      // Load extremes
      tbl.push_back(mk(0, 1, 1, 0, 4'd15, 4'd15, "load15"));
      tbl.push_back(mk(0, 1, 0, 0, 4'd0, 4'd0, "load0"));
      tbl.push_back(mk(0, 1, 0, 1, 4'd10, 4'd10, "load10"));

      foreach (tbl[i]) apply(tbl[i]);

      // Count up to 9, reset mid-count, resume from 0
      apply(mk(0, 1, 0, 1, 4'd8, 4'd8, "seq_load8"));
      apply(mk(0, 0, 1, 1, 4'd0, 4'd9, "seq_up9"));
      apply(mk(1, 0, 1, 1, 4'd0, 4'd0, "seq_reset_mid"));
      apply(mk(0, 0, 1, 1, 4'd0, 4'd1, "seq_resume"));

      // Inputs changed mid-cycle must not reach cn before the edge
      @(negedge clk);
      load = 1'b1; cin = 4'd6; en = 1'b1; ud = 1'b0;
      #2;
      check("no_comb_path", 4'd1);
      @(posedge clk);
      #1;
      check("load6_after_edge", 4'd6);

      // Saturation/wrap at the top end after a load
      apply(mk(0, 1, 0, 0, 4'd14, 4'd14, "seq_load14"));
      apply(mk(0, 0, 1, 1, 4'd0, 4'd15, "seq_up15"));
      apply(mk(0, 0, 1, 1, 4'd0, SAT ? 4'd15 : 4'd0, "seq_top_edge"));
      apply(mk(0, 0, 1, 0, 4'd0, SAT ? 4'd14 : 4'd15, "seq_back_down"));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
